// File: rtl/cpu_pkg.sv
// Shared CPU-side types: memory arbiter state encoding and access-owner codes.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Single-port memory arbiter between fetch and load/store, one access in flight,
// load/store priority with a starvation guard for fetch. All outputs registered.
module mem_bus_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_valid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int LAT_W    = $clog2(MEM_LAT + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    arb_state_t          state_q, state_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                if_gnt_q, if_gnt_d;
    logic                ls_gnt_q, ls_gnt_d;
    logic                if_valid_q, if_valid_d;
    logic                ls_valid_q, ls_valid_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;

    logic fetch_starved;
    assign fetch_starved = if_req && (starve_q == STARVE_W'(STARVE_MAX));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        rdata_d     = rdata_q;
        if_gnt_d    = 1'b0;
        ls_gnt_d    = 1'b0;
        if_valid_d  = 1'b0;
        ls_valid_d  = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        // Grant/strobe outputs are computed here so they appear registered in ISSUE.
        case (state_q)
            IDLE: begin
                if (!if_req) begin
                    starve_d = '0;
                end
                if (ls_req && !fetch_starved) begin
                    state_d     = ISSUE;
                    owner_d     = OWN_LS;
                    we_d        = ls_we;
                    ls_gnt_d    = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = ls_we;
                    mem_addr_d  = ls_addr;
                    mem_wdata_d = ls_wdata;
                    if (if_req) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end else if (if_req) begin
                    state_d     = ISSUE;
                    owner_d     = OWN_IF;
                    we_d        = 1'b0;
                    if_gnt_d    = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                lat_d   = LAT_W'(MEM_LAT);
            end
            WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    state_d = RESP;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    if (owner_q == OWN_LS) begin
                        ls_valid_d = 1'b1;
                    end else begin
                        if_valid_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            lat_q       <= '0;
            starve_q    <= '0;
            rdata_q     <= '0;
            if_gnt_q    <= 1'b0;
            ls_gnt_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            ls_valid_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            rdata_q     <= rdata_d;
            if_gnt_q    <= if_gnt_d;
            ls_gnt_q    <= ls_gnt_d;
            if_valid_q  <= if_valid_d;
            ls_valid_q  <= ls_valid_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign ls_gnt    = ls_gnt_q;
    assign if_valid  = if_valid_q;
    assign ls_valid  = ls_valid_q;
    assign if_rdata  = rdata_q;
    assign ls_rdata  = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single-port instruction/data memory between the fetch path (instruction and 2-byte operand fetch) and the load/store path (LDA and register writeback to memory). Arbitration is fixed-priority to load/store with a starvation guard for fetch, and only one access is in flight at a time. The block sits between the control-signal FSM's fetch/load requests and the memory macro, and returns read data with a valid pulse to the requester that owns the access.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 16, data width
- MEM_LAT, 2, memory read latency in cycles from the mem_en cycle to mem_rdata valid (≥1)
- STARVE_MAX, 3, consecutive load/store wins tolerated while fetch waits
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req / if_addr  in  1 / ADDR_W  fetch request and address
- if_gnt / if_valid  out  1 / 1  fetch accepted pulse; fetch data valid pulse
- if_rdata  out  DATA_W  read data to fetch
- ls_req / ls_we  in  1 / 1  load/store request; 1 = write
- ls_addr / ls_wdata  in  ADDR_W / DATA_W  load/store address and write data
- ls_gnt / ls_valid  out  1 / 1  load/store accepted pulse; read-data or write-ack pulse
- ls_rdata  out  DATA_W  read data to load/store
- mem_en / mem_we  out  1 / 1  memory strobe and write enable
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address and write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE: arbitrates among requests sampled this cycle. ls wins unless if_req=1 and starve_cnt==STARVE_MAX. With one requester, that requester wins. Winner → ISSUE, owner latched; no request → stay in IDLE.
- ISSUE (1 cycle): winner's gnt=1; mem_en=1; mem_addr/mem_we/mem_wdata come from the winner (fetch drives mem_we=0 and mem_wdata=0). Next state is WAIT with lat_cnt=MEM_LAT.
- WAIT (MEM_LAT cycles): mem_en=0. lat_cnt decrements each cycle. In the final WAIT cycle, mem_rdata is captured into rdata_q for reads; for writes rdata_q holds its value. → RESP.
- RESP (1 cycle): owner's valid=1; if_rdata=ls_rdata=rdata_q. → IDLE.
- Requester rules:
  - Requesters hold req/addr/wdata stable until gnt.
  - req is ignored outside IDLE.
  - A req held through RESP is re-arbitrated in IDLE as a new access.
- starve_cnt, width $clog2(STARVE_MAX+1):
  - +1 on each ls grant while if_req=1.
  - Cleared on fetch grant.
  - Cleared in IDLE when if_req=0.
  - Saturates at STARVE_MAX.
- rdata_q keeps its value until the next read capture.

## Timing
- Reset values: state IDLE; every output 0, including rdata_q, busy and starve_cnt.
- Reset mid-operation clears state immediately with no valid pulse; the abandoned access's mem_rdata is ignored.
- Request sampled in IDLE at cycle 0:
  - gnt and mem_en in cycle 1.
  - mem_rdata valid in cycle 1+MEM_LAT.
  - valid and rdata in cycle 2+MEM_LAT.
  - IDLE in cycle 3+MEM_LAT.
- Throughput: one access per MEM_LAT+3 cycles under continuous requests.
- Simultaneous if_req and ls_req are decided only by the priority/starve rule; never grant both.
- Writes complete identically, with ls_valid acting as write-ack at 2+MEM_LAT.

## Structure
- Shared package cpu_pkg holds:
  - arb_state_t enum (IDLE, ISSUE, WAIT, RESP).
  - Owner encoding OWN_IF=0, OWN_LS=1.
- Single module with no sub-module; the latency counter and starve counter are inline.

## Test plan
All scenarios use MEM_LAT=2, STARVE_MAX=3.
- Fetch read: if_req at cycle 0 with addr 0x05, memory returns 0x1234 → if_gnt and mem_en with mem_addr 0x05 in cycle 1; if_valid with if_rdata 0x1234 in cycle 4; busy low in cycle 5.
- Contention: if_req and ls_req both rise in cycle 0 with starve_cnt=0 → ls_gnt in cycle 1, if_gnt not before cycle 6.
- Starvation: both requests held continuously → grant order LS, LS, LS, IF, LS, LS, LS, IF.
- Write: ls_we=1, addr 0x10, data 0xBEEF → in cycle 1 mem_we=1, mem_addr 0x10, mem_wdata 0xBEEF; ls_valid in cycle 4; ls_rdata keeps its previous value.
- Reset in WAIT: rst pulsed in cycle 2 → all outputs 0 at once; no valid pulse despite mem_rdata in cycle 3; a new if_req then completes with standard timing.
- Back-to-back fetch: if_req held high → if_gnt in cycles 1 and 6, if_valid in cycles 4 and 9.
